// File: rtl/ncl4_rx_sync.sv
// ---------------------------------------------------------------------------
// ncl4_rx_sync
//
// Purpose:
//   Clocked-domain receiver for a 1-of-4 (four-rail) NCL wavefront stream.
//   Each rail is brought into the clock domain through a flop synchroniser.
//   A stability filter then makes sure the sampled rails have settled before
//   any decision is made. A two-state handshake FSM drives the completion
//   signal back to the NCL producer. Legal DATA wavefronts are decoded to
//   2 bits and buffered in a small valid/ready FIFO. Multi-hot wavefronts
//   are flagged and counted, and are not buffered.
//
// Ports:
//   clk        in   1      single clock, all state on rising edge
//   init       in   1      asynchronous active-high reset
//   in         in   4      NCL 1-of-4 rails, asynchronous to clk
//   inCOMP     out  1      completion: 1 = request NULL, 0 = request DATA
//   out_data   out  2      decoded value at FIFO head (holds when empty)
//   out_valid  out  1      FIFO non-empty
//   out_ready  in   1      consumer pops head when out_valid & out_ready
//   err        out  1      one-cycle pulse on a multi-hot wavefront
//   wf_count   out  CNT_W  accepted DATA wavefronts, wraps
//   err_count  out  CNT_W  illegal wavefronts, saturates at all-ones
// ---------------------------------------------------------------------------
module ncl4_rx_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2,
  parameter int DEPTH         = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             init,
  input  logic [3:0]       in,
  output logic             inCOMP,
  output logic [1:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  output logic [CNT_W-1:0] wf_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] STABLE_V = CW'(STABLE_CYCLES);
  localparam logic [FW-1:0] FILL_V   = FW'(SYNC_STAGES);

  typedef enum logic [0:0] {
    WAIT_NULL = 1'b0,
    WAIT_DATA = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]    sampled;
  logic [3:0]    filt_q;
  logic [CW-1:0] stableCnt_q;
  logic [FW-1:0] fill_q;
  logic          stable;
  logic          oneHot;

  state_e        state_q, state_d;
  logic          inComp_q;
  logic          err_q;
  logic          fifoWr;
  logic          errPulse;
  logic [1:0]    wrData;

  logic [1:0]    mem_q [DEPTH];
  logic [AW:0]   wrPtr_q, wrPtr_d;
  logic [AW:0]   rdPtr_q, rdPtr_d;
  logic          fifoFull;
  logic          fifoRd;
  logic [1:0]    outData_q, outData_d;

  logic [CNT_W-1:0] wfCount_q;
  logic [CNT_W-1:0] errCount_q;

  // Rail synchroniser: stage 0 captures the raw rails, the last stage is the
  // sample the rest of the block trusts.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end
  end

  assign sampled = sync_q[SYNC_STAGES-1];

  // Stability filter. The run count is held at 0 until the synchroniser has
  // been refilled after reset, so values that were reset into the chain are
  // never treated as observed rail levels. filt_q is the sample the run
  // count refers to.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      fill_q      <= '0;
      stableCnt_q <= '0;
      filt_q      <= '0;
    end else begin
      filt_q <= sampled;
      if (fill_q != FILL_V) begin
        fill_q      <= fill_q + 1'b1;
        stableCnt_q <= '0;
      end else if (stableCnt_q == '0 || sampled != filt_q) begin
        stableCnt_q <= CW'(1);
      end else if (stableCnt_q != STABLE_V) begin
        stableCnt_q <= stableCnt_q + 1'b1;
      end
    end
  end

  assign stable = (stableCnt_q == STABLE_V);
  assign oneHot = (filt_q != 4'b0000) && ((filt_q & (filt_q - 4'b0001)) == 4'b0000);

  // Rail k of a one-hot wavefront carries value k.
  always_comb begin
    wrData = 2'd0;
    case (filt_q)
      4'b0010: wrData = 2'd1;
      4'b0100: wrData = 2'd2;
      4'b1000: wrData = 2'd3;
      default: wrData = 2'd0;
    endcase
  end

  // Handshake FSM state register plus the registered completion and error
  // outputs, so nothing combinational reaches the NCL domain.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_q  <= WAIT_NULL;
      inComp_q <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      inComp_q <= (state_d == WAIT_NULL);
      err_q    <= errPulse;
    end
  end

  // Next-state logic. DATA is only requested when the FIFO has room, which
  // guarantees that a captured wavefront always finds a free entry.
  always_comb begin
    state_d  = state_q;
    fifoWr   = 1'b0;
    errPulse = 1'b0;
    unique case (state_q)
      WAIT_NULL: begin
        if (stable && filt_q == 4'b0000 && !fifoFull) begin
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (stable && filt_q != 4'b0000) begin
          state_d = WAIT_NULL;
          if (oneHot) begin
            fifoWr = 1'b1;
          end else begin
            errPulse = 1'b1;
          end
        end
      end
      default: state_d = WAIT_NULL;
    endcase
  end

  assign out_valid = (wrPtr_q != rdPtr_q);
  assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign fifoRd    = out_valid && out_ready;

  // FIFO pointer and head-register next state. The head register tracks the
  // entry at the read pointer after this edge. When the FIFO is about to
  // become empty it keeps its last value. A write into an empty FIFO
  // bypasses the storage, so the value shows up together with out_valid.
  always_comb begin
    wrPtr_d   = wrPtr_q + (AW+1)'(fifoWr);
    rdPtr_d   = rdPtr_q + (AW+1)'(fifoRd);
    outData_d = outData_q;
    if (wrPtr_d != rdPtr_d) begin
      if (fifoWr && rdPtr_d[AW-1:0] == wrPtr_q[AW-1:0]) begin
        outData_d = wrData;
      end else begin
        outData_d = mem_q[rdPtr_d[AW-1:0]];
      end
    end
  end

  // FIFO storage, no reset needed: an entry is only read after being written.
  always_ff @(posedge clk) begin
    if (fifoWr) begin
      mem_q[wrPtr_q[AW-1:0]] <= wrData;
    end
  end

  // FIFO pointers and head register. Reset discards any buffered entries.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      outData_q <= 2'd0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      outData_q <= outData_d;
    end
  end

  // Wavefront counters. The DATA count wraps. The error count sticks at its
  // maximum so a flood of bad wavefronts can never read back as few.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      wfCount_q  <= '0;
      errCount_q <= '0;
    end else begin
      if (fifoWr) begin
        wfCount_q <= wfCount_q + 1'b1;
      end
      if (errPulse && errCount_q != {CNT_W{1'b1}}) begin
        errCount_q <= errCount_q + 1'b1;
      end
    end
  end

  assign inCOMP    = inComp_q;
  assign err       = err_q;
  assign out_data  = outData_q;
  assign wf_count  = wfCount_q;
  assign err_count = errCount_q;

endmodule
